// File: rtl/uaz8_dw_pkg.sv
// Shared DW source-select codes and write-back FSM state encoding.
// Used by the DW source mux and by dw_write_ctrl.
package uaz8_dw_pkg;

  localparam logic [2:0] SEL_R0   = 3'b000;
  localparam logic [2:0] SEL_BUS  = 3'b001;
  localparam logic [2:0] SEL_NUM  = 3'b010;
  localparam logic [2:0] SEL_ADDR = 3'b011;
  localparam logic [2:0] SEL_RY   = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUS_WAIT = 2'd1,
    ST_WRITE    = 2'd2
  } dw_state_e;

  // Codes above SEL_RY have no DW source behind them.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= SEL_RY);
  endfunction

endpackage

// File: rtl/dw_timeout_cnt.sv
// Bus-wait timeout counter: clear/enable, saturates at TIMEOUT_CYC-1, 1-cycle registered count.
// No backpressure; o_tc is combinational from the count register.
module dw_timeout_cnt
  import uaz8_dw_pkg::*;
#(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != TC_VAL)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/dw_write_ctrl.sv
// Register-file write-back sequencer: 1-cycle latency for direct sources, bus loads wait for ack/timeout.
// i_start is ignored while o_busy (BUS_WAIT); all outputs are registered.
module dw_write_ctrl
  import uaz8_dw_pkg::*;
#(
  parameter int REG_AW      = 3,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [2:0]        i_op,
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_bus_ack,
  output logic [2:0]        o_sel_dw,
  output logic              o_reg_we,
  output logic [REG_AW-1:0] o_reg_waddr,
  output logic              o_bus_rd,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  dw_state_e         r_state;
  dw_state_e         w_nxt_state;
  logic [2:0]        r_op;
  logic [REG_AW-1:0] r_rd;

  logic [2:0]        w_nxt_sel;
  logic [REG_AW-1:0] w_nxt_waddr;
  logic              w_nxt_we;
  logic              w_nxt_bus_rd;
  logic              w_nxt_err;
  logic              w_latch;
  logic              w_cnt_clr;
  logic              w_cnt_en;
  logic              w_tc;

  dw_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_comb begin
    w_nxt_state  = ST_IDLE;
    w_nxt_sel    = o_sel_dw;
    w_nxt_waddr  = o_reg_waddr;
    w_nxt_we     = 1'b0;
    w_nxt_bus_rd = 1'b0;
    w_nxt_err    = 1'b0;
    w_latch      = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_en     = 1'b0;

    case (r_state)
      ST_IDLE, ST_WRITE: begin
        if (i_start) begin
          w_latch = 1'b1;
          if (i_op == SEL_BUS) begin
            w_nxt_state  = ST_BUS_WAIT;
            w_nxt_bus_rd = 1'b1;
            w_nxt_sel    = SEL_BUS;
            w_cnt_clr    = 1'b1;
          end else if (op_is_legal(i_op)) begin
            w_nxt_state = ST_WRITE;
            w_nxt_we    = 1'b1;
            w_nxt_sel   = i_op;
            w_nxt_waddr = i_rd;
          end else begin
            w_nxt_err = 1'b1;
          end
        end
      end
      ST_BUS_WAIT: begin
        // Ack takes priority over a timeout on the same cycle.
        if (i_bus_ack) begin
          w_nxt_state = ST_WRITE;
          w_nxt_we    = 1'b1;
          w_nxt_sel   = r_op;
          w_nxt_waddr = r_rd;
        end else if (w_tc) begin
          w_nxt_err = 1'b1;
        end else begin
          w_nxt_state  = ST_BUS_WAIT;
          w_nxt_bus_rd = 1'b1;
          w_cnt_en     = 1'b1;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op        <= SEL_R0;
      r_rd        <= '0;
      o_sel_dw    <= SEL_R0;
      o_reg_waddr <= '0;
      o_reg_we    <= 1'b0;
      o_done      <= 1'b0;
      o_bus_rd    <= 1'b0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      if (w_latch) begin
        r_op <= i_op;
        r_rd <= i_rd;
      end
      o_sel_dw    <= w_nxt_sel;
      o_reg_waddr <= w_nxt_waddr;
      o_reg_we    <= w_nxt_we;
      o_done      <= w_nxt_we;
      o_bus_rd    <= w_nxt_bus_rd;
      o_busy      <= (w_nxt_state == ST_BUS_WAIT);
      o_err       <= w_nxt_err;
    end
  end

endmodule

// File: tb/tb_dw_write_ctrl.sv
// Directed vector bench for dw_write_ctrl: one vector per clock, outputs checked 1 time unit after the edge.
module tb_dw_write_ctrl;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [2:0] rd;
  logic       ack;
  logic [2:0] sel_dw;
  logic       reg_we;
  logic [2:0] reg_waddr;
  logic       bus_rd;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dw_write_ctrl #(
    .REG_AW      (3),
    .TIMEOUT_CYC (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_op        (op),
    .i_rd        (rd),
    .i_bus_ack   (ack),
    .o_sel_dw    (sel_dw),
    .o_reg_we    (reg_we),
    .o_reg_waddr (reg_waddr),
    .o_bus_rd    (bus_rd),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  // Inputs applied during a cycle, and the registered outputs expected after its closing edge.
  typedef struct packed {
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [2:0] rd;
    logic       ack;
    logic [2:0] sel;
    logic       we;
    logic [2:0] wa;
    logic       brd;
    logic       bsy;
    logic       dn;
    logic       er;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic [2:0] o,
                              input logic [2:0] d, input logic a,
                              input logic [2:0] es, input logic ew, input logic [2:0] ea,
                              input logic eb, input logic ey, input logic ed, input logic ee);
    vec_t v;
    v = '{r, s, o, d, a, es, ew, ea, eb, ey, ed, ee};
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    logic [10:0] act;
    logic [10:0] exp;
    rst   = v.rst;
    start = v.start;
    op    = v.op;
    rd    = v.rd;
    ack   = v.ack;
    @(posedge clk);
    #1;
    act = {sel_dw, reg_we, reg_waddr, bus_rd, busy, done, err};
    exp = {v.sel, v.we, v.wa, v.brd, v.bsy, v.dn, v.er};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got sel/we/wa/brd/busy/done/err=%b required %b", name, act, exp);
    end
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; rd = '0; ack = 1'b0;

    //           rst st op      rd      ack  sel     we wa      brd bsy dn er
    // reset held with a bus-load start pending
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 1, 3'd1, 3'd6, 0,  3'd0, 0, 3'd0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 3'd0, 0,  3'd0, 0, 3'd0, 0, 0, 0, 0));
    // direct source, 1-cycle latency, then idle holding sel/waddr
    tbl.push_back(mk(0, 1, 3'd2, 3'd5, 0,  3'd2, 1, 3'd5, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 3'd0, 3'd0, 0,  3'd2, 0, 3'd5, 0, 0, 0, 0));
    // bus load acked in the 4th bus_rd cycle
    tbl.push_back(mk(0, 1, 3'd1, 3'd2, 0,  3'd1, 0, 3'd5, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 3'd0, 3'd0, 0,  3'd1, 0, 3'd5, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 3'd0, 3'd0, 1,  3'd1, 1, 3'd2, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 3'd0, 3'd0, 0,  3'd1, 0, 3'd2, 0, 0, 0, 0));
    // stray ack while idle
    tbl.push_back(mk(0, 0, 3'd0, 3'd0, 1,  3'd1, 0, 3'd2, 0, 0, 0, 0));
    // illegal op, then back-to-back writes
    tbl.push_back(mk(0, 1, 3'd6, 3'd7, 0,  3'd1, 0, 3'd2, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 3'd4, 3'd3, 0,  3'd4, 1, 3'd3, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 3'd0, 3'd1, 0,  3'd0, 1, 3'd1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 3'd0, 3'd0, 0,  3'd0, 0, 3'd1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'd7, 3'd2, 0,  3'd0, 0, 3'd1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 3'd5, 3'd2, 0,  3'd0, 0, 3'd1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 3'd3, 3'd4, 0,  3'd3, 1, 3'd4, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 3'd0, 3'd0, 0,  3'd3, 0, 3'd4, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Timeout: bus_rd high for TO cycles, starts during the wait ignored.
    apply(mk(0, 1, 3'd1, 3'd6, 0,  3'd1, 0, 3'd4, 1, 1, 0, 0), "to_start");
    for (int k = 1; k < TO; k++)
      apply(mk(0, 1, 3'd0, 3'd7, 0,  3'd1, 0, 3'd4, 1, 1, 0, 0), $sformatf("to_wait%0d", k));
    apply(mk(0, 0, 3'd0, 3'd0, 0,  3'd1, 0, 3'd4, 0, 0, 0, 1), "to_err");
    apply(mk(0, 0, 3'd0, 3'd0, 0,  3'd1, 0, 3'd4, 0, 0, 0, 0), "to_idle");

    // Ack arriving on the terminal-count cycle completes the write.
    apply(mk(0, 1, 3'd1, 3'd5, 0,  3'd1, 0, 3'd4, 1, 1, 0, 0), "tcack_start");
    for (int k = 1; k < TO; k++)
      apply(mk(0, 0, 3'd0, 3'd0, 0,  3'd1, 0, 3'd4, 1, 1, 0, 0), $sformatf("tcack_wait%0d", k));
    apply(mk(0, 0, 3'd0, 3'd0, 1,  3'd1, 1, 3'd5, 0, 0, 1, 0), "tcack_write");
    apply(mk(0, 0, 3'd0, 3'd0, 0,  3'd1, 0, 3'd5, 0, 0, 0, 0), "tcack_idle");

    // Reset in BUS_WAIT, late ack ignored.
    apply(mk(0, 1, 3'd1, 3'd3, 0,  3'd1, 0, 3'd5, 1, 1, 0, 0), "rstbw_start");
    apply(mk(0, 0, 3'd0, 3'd0, 0,  3'd1, 0, 3'd5, 1, 1, 0, 0), "rstbw_wait");
    apply(mk(1, 0, 3'd0, 3'd0, 0,  3'd0, 0, 3'd0, 0, 0, 0, 0), "rstbw_rst");
    apply(mk(0, 0, 3'd0, 3'd0, 1,  3'd0, 0, 3'd0, 0, 0, 0, 0), "rstbw_ack");
    apply(mk(0, 0, 3'd0, 3'd0, 0,  3'd0, 0, 3'd0, 0, 0, 0, 0), "rstbw_idle");

    // Fresh request still works after reset.
    apply(mk(0, 1, 3'd4, 3'd6, 0,  3'd4, 1, 3'd6, 0, 0, 1, 0), "post_rst_wr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
